// File: rtl/tlb_pkg.sv
// Shared types and constants for the TLB controller and its victim selector.
package tlb_pkg;

  localparam int TLB_ENTRIES = 4;
  localparam int VPN_W       = 6;
  localparam int PPN_W       = 2;

  localparam logic PT_RW_READ  = 1'b0;
  localparam logic PT_RW_WRITE = 1'b1;

  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
    logic             dirty;
    logic             referenced;
  } tlb_entry_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WB     = 3'd2,
    WALK   = 3'd3,
    FILL   = 3'd4,
    RESP   = 3'd5
  } tlb_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tlb_victim_sel.sv
// Combinational victim pick: lowest-index invalid entry, else the round-robin pointer.
// victim_valid_o=1 means the chosen slot holds a live entry that must be written back.
module tlb_victim_sel
  import tlb_pkg::*;
#(
  parameter int ENTRIES = TLB_ENTRIES,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] valid_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [IDX_W-1:0]   victim_idx_o,
  output logic               victim_valid_o
);

  always_comb begin
    victim_idx_o   = rr_ptr_i;
    victim_valid_o = 1'b1;
    // Descending scan so the lowest free index is the last one written.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        victim_idx_o   = IDX_W'(i);
        victim_valid_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tlb_controller.sv
// Fully associative TLB in front of the page table; hit answers 2 clk after accept, miss 3 + walk (+ WB) clk.
// No response backpressure; req_ready only in IDLE without flush. Optional counters under TLB_STATS_EN.
module tlb_controller
  import tlb_pkg::*;
#(
  parameter int ENTRIES = TLB_ENTRIES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [VPN_W-1:0] req_vpn,
  input  logic             req_write,
  input  logic             flush,
  output logic             req_ready,
  output logic             resp_valid,
  output logic [PPN_W-1:0] resp_ppn,
  output logic             resp_hit,
  output logic             resp_fault,
  output logic             pt_req,
  output logic             pt_rw,
  output logic [VPN_W-1:0] pt_vpn,
  output logic             pt_dirty_wb,
  output logic             pt_ref_wb,
  input  logic             pt_done,
  input  logic [PPN_W-1:0] pt_ppn,
  input  logic             pt_fault,
  input  logic             pt_dirty,
  input  logic             pt_ref
`ifdef TLB_STATS_EN
  , output logic [15:0]    hit_count
  , output logic [15:0]    miss_count
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);

  tlb_state_e       state_q, state_d;
  tlb_entry_t       entries_q [ENTRIES];
  tlb_entry_t       entries_d [ENTRIES];
  logic [VPN_W-1:0] vpn_q, vpn_d;
  logic             write_q, write_d;
  logic [IDX_W-1:0] victim_q, victim_d;
  logic             evict_q, evict_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic             flush_pend_q, flush_pend_d;
  logic [PPN_W-1:0] fill_ppn_q, fill_ppn_d;
  logic             fill_dirty_q, fill_dirty_d;
  logic             fill_ref_q, fill_ref_d;
  logic             rsp_hit_q, rsp_hit_d;
  logic             rsp_fault_q, rsp_fault_d;
  logic [PPN_W-1:0] rsp_ppn_q, rsp_ppn_d;

  logic [ENTRIES-1:0] valid_vec;
  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [IDX_W-1:0]   vs_idx;
  logic               vs_valid;
  logic               flush_apply;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      valid_vec[i] = entries_q[i].valid;
      if (entries_q[i].valid && (entries_q[i].vpn == vpn_q)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  tlb_victim_sel #(.ENTRIES(ENTRIES)) u_victim_sel (
    .valid_i        (valid_vec),
    .rr_ptr_i       (rr_q),
    .victim_idx_o   (vs_idx),
    .victim_valid_o (vs_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!flush && req_valid) state_d = LOOKUP;
      LOOKUP:  state_d = hit ? RESP : (vs_valid ? WB : WALK);
      WB:      if (pt_done) state_d = WALK;
      WALK:    if (pt_done) state_d = pt_fault ? RESP : FILL;
      FILL:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state_q == IDLE) && !flush;
    resp_valid  = (state_q == RESP);
    resp_hit    = (state_q == RESP) && rsp_hit_q;
    resp_fault  = (state_q == RESP) && rsp_fault_q;
    resp_ppn    = (state_q == RESP) ? rsp_ppn_q : '0;
    pt_req      = (state_q == WB) || (state_q == WALK);
    pt_rw       = (state_q == WB) ? PT_RW_WRITE : PT_RW_READ;
    pt_vpn      = '0;
    pt_dirty_wb = 1'b0;
    pt_ref_wb   = 1'b0;
    if (state_q == WB) begin
      pt_vpn      = entries_q[victim_q].vpn;
      pt_dirty_wb = entries_q[victim_q].dirty;
      pt_ref_wb   = entries_q[victim_q].referenced;
    end else if (state_q == WALK) begin
      pt_vpn = vpn_q;
    end
  end

  always_comb begin
    entries_d    = entries_q;
    vpn_d        = vpn_q;
    write_d      = write_q;
    victim_d     = victim_q;
    evict_d      = evict_q;
    rr_d         = rr_q;
    flush_pend_d = flush_pend_q;
    fill_ppn_d   = fill_ppn_q;
    fill_dirty_d = fill_dirty_q;
    fill_ref_d   = fill_ref_q;
    rsp_hit_d    = rsp_hit_q;
    rsp_fault_d  = rsp_fault_q;
    rsp_ppn_d    = rsp_ppn_q;
    flush_apply  = 1'b0;

    if (flush && (state_q != IDLE) && (state_q != RESP)) flush_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (flush) begin
          flush_apply = 1'b1;
        end else if (req_valid) begin
          vpn_d   = req_vpn;
          write_d = req_write;
        end
      end
      LOOKUP: begin
        if (hit) begin
          entries_d[hit_idx].referenced = 1'b1;
          entries_d[hit_idx].dirty      = entries_q[hit_idx].dirty | write_q;
          rsp_hit_d   = 1'b1;
          rsp_fault_d = 1'b0;
          rsp_ppn_d   = entries_q[hit_idx].ppn;
        end else begin
          victim_d = vs_idx;
          evict_d  = vs_valid;
        end
      end
      WALK: begin
        if (pt_done) begin
          if (pt_fault) begin
            // The victim's state now lives only in the page table, so drop it.
            if (evict_q) entries_d[victim_q].valid = 1'b0;
            rsp_hit_d   = 1'b0;
            rsp_fault_d = 1'b1;
            rsp_ppn_d   = '0;
          end else begin
            fill_ppn_d   = pt_ppn;
            fill_dirty_d = pt_dirty | write_q;
            fill_ref_d   = pt_ref | 1'b1;
          end
        end
      end
      FILL: begin
        entries_d[victim_q] = '{valid: 1'b1, vpn: vpn_q, ppn: fill_ppn_q,
                                dirty: fill_dirty_q, referenced: fill_ref_q};
        if (evict_q) rr_d = rr_q + IDX_W'(1);
        rsp_hit_d   = 1'b0;
        rsp_fault_d = 1'b0;
        rsp_ppn_d   = fill_ppn_q;
      end
      RESP: begin
        if (flush || flush_pend_q) begin
          flush_apply  = 1'b1;
          flush_pend_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (flush_apply) begin
      for (int i = 0; i < ENTRIES; i++) entries_d[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
      vpn_q        <= '0;
      write_q      <= 1'b0;
      victim_q     <= '0;
      evict_q      <= 1'b0;
      rr_q         <= '0;
      flush_pend_q <= 1'b0;
      fill_ppn_q   <= '0;
      fill_dirty_q <= 1'b0;
      fill_ref_q   <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_fault_q  <= 1'b0;
      rsp_ppn_q    <= '0;
    end else begin
      entries_q    <= entries_d;
      vpn_q        <= vpn_d;
      write_q      <= write_d;
      victim_q     <= victim_d;
      evict_q      <= evict_d;
      rr_q         <= rr_d;
      flush_pend_q <= flush_pend_d;
      fill_ppn_q   <= fill_ppn_d;
      fill_dirty_q <= fill_dirty_d;
      fill_ref_q   <= fill_ref_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_fault_q  <= rsp_fault_d;
      rsp_ppn_q    <= rsp_ppn_d;
    end
  end

`ifdef TLB_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  // A flush applied on the RESP edge wins over that response's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (flush_apply) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == RESP) begin
      if (rsp_hit_q) hit_cnt_q  <= sat_inc(hit_cnt_q);
      else           miss_cnt_q <= sat_inc(miss_cnt_q);
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_tlb_controller.sv
// Randomized bench for tlb_controller with a transaction-level TLB/page-table model.
module tb_tlb_controller;

  localparam int NE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [5:0] req_vpn = '0;
  logic       req_write = 1'b0;
  logic       flush = 1'b0;
  logic       req_ready, resp_valid, resp_hit, resp_fault;
  logic [1:0] resp_ppn;
  logic       pt_req, pt_rw, pt_dirty_wb, pt_ref_wb;
  logic [5:0] pt_vpn;
  logic       pt_done = 1'b0;
  logic [1:0] pt_ppn = '0;
  logic       pt_fault = 1'b0;
  logic       pt_dirty = 1'b0;
  logic       pt_ref = 1'b0;
`ifdef TLB_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  tlb_controller dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_vpn(req_vpn),
    .req_write(req_write), .flush(flush), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ppn(resp_ppn), .resp_hit(resp_hit),
    .resp_fault(resp_fault), .pt_req(pt_req), .pt_rw(pt_rw), .pt_vpn(pt_vpn),
    .pt_dirty_wb(pt_dirty_wb), .pt_ref_wb(pt_ref_wb), .pt_done(pt_done),
    .pt_ppn(pt_ppn), .pt_fault(pt_fault), .pt_dirty(pt_dirty), .pt_ref(pt_ref)
`ifdef TLB_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Page table contents seen by the bench's responder.
  logic [1:0] tbl_ppn   [64];
  bit         tbl_fault [64];
  bit         tbl_dirty [64];

  // Reference TLB state.
  bit         m_valid [NE];
  logic [5:0] m_vpn   [NE];
  logic [1:0] m_ppn   [NE];
  bit         m_dirty [NE];
  bit         m_ref   [NE];
  int         m_rr;
  int         m_hitc, m_missc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_flush();
    for (int i = 0; i < NE; i++) m_valid[i] = 0;
    m_hitc  = 0;
    m_missc = 0;
  endtask

  task automatic model_reset();
    model_flush();
    for (int i = 0; i < NE; i++) begin
      m_vpn[i] = '0; m_ppn[i] = '0; m_dirty[i] = 0; m_ref[i] = 0;
    end
    m_rr = 0;
  endtask

  task automatic predict(input logic [5:0] vpn, input bit wr,
                         output bit hit, output bit wb, output logic [5:0] wbvpn,
                         output bit wbd, output bit wbr, output bit flt, output logic [1:0] ppn);
    int v;
    hit = 0; wb = 0; wbvpn = '0; wbd = 0; wbr = 0; flt = 0; ppn = '0; v = -1;
    for (int i = 0; i < NE; i++)
      if (m_valid[i] && m_vpn[i] == vpn) begin hit = 1; v = i; end
    if (hit) begin
      m_ref[v]   = 1;
      m_dirty[v] = m_dirty[v] | wr;
      ppn        = m_ppn[v];
      if (m_hitc < 65535) m_hitc++;
    end else begin
      for (int i = NE - 1; i >= 0; i--) if (!m_valid[i]) v = i;
      if (v < 0) begin
        v = m_rr; wb = 1; wbvpn = m_vpn[v]; wbd = m_dirty[v]; wbr = m_ref[v];
      end
      flt = tbl_fault[vpn];
      if (flt) begin
        if (wb) m_valid[v] = 0;
      end else begin
        m_valid[v] = 1; m_vpn[v] = vpn; m_ppn[v] = tbl_ppn[vpn];
        m_dirty[v] = tbl_dirty[vpn] | wr; m_ref[v] = 1;
        ppn = tbl_ppn[vpn];
        if (wb) m_rr = (m_rr + 1) % NE;
      end
      if (m_missc < 65535) m_missc++;
    end
  endtask

  // Issue one request, act as the page table, and check every cycle until the response.
  task automatic run_txn(input logic [5:0] vpn, input bit wr, input int dw, input int dv,
                         input bit fl_walk, output bit o_hit, output bit o_flt,
                         output logic [1:0] o_ppn, output logic [5:0] o_wbvpn, output bit o_wbd);
    bit e_hit, e_wb, e_wbd, e_wbr, e_flt, got, flushed;
    logic [5:0] e_wbvpn;
    logic [1:0] e_ppn;
    int t, k, exp_k, phase, cnt;
    o_hit = 0; o_flt = 0; o_ppn = '0; o_wbvpn = '0; o_wbd = 0;
    t = 0;
    while (!req_ready && t < 32) begin @(negedge clk); t++; end
    chk("req_ready_wait", req_ready, 1);
    if (!req_ready) return;
    predict(vpn, wr, e_hit, e_wb, e_wbvpn, e_wbd, e_wbr, e_flt, e_ppn);
    req_valid = 1; req_vpn = vpn; req_write = wr;
    pt_done = ($urandom_range(0, 3) == 0); pt_ppn = 2'($urandom); pt_fault = 1'($urandom);
    @(negedge clk);
    req_valid = 0; req_vpn = 6'($urandom); req_write = 1'($urandom);
    exp_k = e_hit ? 2 : 2 + (e_wb ? dw + 1 : 0) + dv + 1 + (e_flt ? 0 : 1);
    phase = e_hit ? 3 : (e_wb ? 1 : 2);
    cnt = 0; got = 0; flushed = 0; k = 1;
    while (!got && k < 64) begin
      pt_done = 0; flush = 0;
      if (resp_valid) begin
        got = 1;
        chk("resp_latency", k, exp_k);
        chk("resp_hit", resp_hit, e_hit);
        chk("resp_fault", resp_fault, e_flt);
        chk("resp_ppn", resp_ppn, e_ppn);
        o_hit = resp_hit; o_flt = resp_fault; o_ppn = resp_ppn;
      end else if (pt_req) begin
        if (phase == 1) begin
          chk("wb_rw", pt_rw, 1);
          chk("wb_vpn", pt_vpn, e_wbvpn);
          chk("wb_dirty", pt_dirty_wb, e_wbd);
          chk("wb_ref", pt_ref_wb, e_wbr);
          o_wbvpn = pt_vpn; o_wbd = pt_dirty_wb;
          if (cnt == dw) begin
            pt_done = 1; pt_ppn = 2'($urandom); pt_fault = 1'($urandom);
            pt_dirty = 1'($urandom); pt_ref = 1'($urandom);
            phase = 2; cnt = 0;
          end else cnt++;
        end else if (phase == 2) begin
          chk("walk_rw", pt_rw, 0);
          chk("walk_vpn", pt_vpn, vpn);
          if (fl_walk && cnt == 0) begin flush = 1; flushed = 1; end
          if (cnt == dv) begin
            pt_done = 1; pt_ppn = tbl_ppn[vpn]; pt_fault = tbl_fault[vpn];
            pt_dirty = tbl_dirty[vpn]; pt_ref = 1'($urandom);
            phase = 3;
          end else cnt++;
        end else begin
          chk("pt_req_unexpected", pt_req, 0);
        end
      end
      @(negedge clk);
      k++;
    end
    pt_done = 0; flush = 0;
    chk("resp_seen", got, 1);
    chk("resp_one_cycle", resp_valid, 0);
    if (flushed) model_flush();
  endtask

  task automatic flush_idle();
    int t;
    t = 0;
    while (!req_ready && t < 32) begin @(negedge clk); t++; end
    flush = 1; req_valid = 1; req_vpn = m_vpn[0];
    #1 chk("flush_blocks_ready", req_ready, 0);
    @(negedge clk);
    flush = 0; req_valid = 0;
    model_flush();
    #1 chk("ready_after_flush", req_ready, 1);
    repeat (3) begin
      @(negedge clk);
      chk("flush_no_resp", resp_valid, 0);
      chk("flush_no_pt", pt_req, 0);
    end
  endtask

  task automatic reset_mid_walk(input logic [5:0] vpn);
    int t;
    t = 0;
    while (!req_ready && t < 32) begin @(negedge clk); t++; end
    req_valid = 1; req_vpn = vpn; req_write = 0;
    @(negedge clk);
    req_valid = 0;
    t = 0;
    while (!(pt_req && pt_rw == 0) && t < 16) begin @(negedge clk); t++; end
    chk("walk_reached", pt_req, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_pt_req", pt_req, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_resp", resp_valid, 0);
      chk("post_rst_no_pt", pt_req, 0);
      chk("post_rst_ready", req_ready, 1);
    end
`ifdef TLB_STATS_EN
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit h, f, wd;
    logic [1:0] p;
    logic [5:0] wv;

    for (int v = 0; v < 64; v++) begin
      tbl_ppn[v]   = 2'($urandom);
      tbl_fault[v] = ($urandom_range(0, 7) == 0);
      tbl_dirty[v] = 1'($urandom);
    end
    tbl_ppn[0] = 2'd1; tbl_fault[0] = 0; tbl_dirty[0] = 0;
    tbl_ppn[7] = 2'd1; tbl_fault[7] = 0;
    tbl_fault[1] = 0; tbl_fault[3] = 0; tbl_fault[4] = 0;
    tbl_fault[9] = 0; tbl_fault[10] = 0;
    tbl_fault[2] = 1;
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid0", resp_valid, 0);
    chk("rst_resp_ppn", resp_ppn, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_fault", resp_fault, 0);
    chk("rst_pt_req0", pt_req, 0);
    chk("rst_pt_rw", pt_rw, 0);
    chk("rst_pt_vpn", pt_vpn, 0);
    chk("rst_pt_wb_bits", {pt_dirty_wb, pt_ref_wb}, 0);
    rst_n = 1;
    @(negedge clk);

    // Cold miss then hit on vpn 0.
    run_txn(6'd0, 0, 0, 2, 0, h, f, p, wv, wd);
    chk("lit_miss0_hit", h, 0);
    chk("lit_miss0_ppn", p, 1);
    chk("lit_miss0_fault", f, 0);
    run_txn(6'd0, 0, 0, 0, 0, h, f, p, wv, wd);
    chk("lit_hit0_hit", h, 1);
    chk("lit_hit0_ppn", p, 1);

    // Faulting page, twice: the second must walk again.
    run_txn(6'd2, 0, 0, 1, 0, h, f, p, wv, wd);
    chk("lit_fault_flag", f, 1);
    chk("lit_fault_ppn", p, 0);
    run_txn(6'd2, 0, 0, 0, 0, h, f, p, wv, wd);
    chk("lit_fault2_flag", f, 1);
    chk("lit_fault2_hit", h, 0);

    // Fill the TLB, then evict entry 0 via write-back.
    run_txn(6'd1, 0, 0, 0, 0, h, f, p, wv, wd);
    run_txn(6'd3, 0, 0, 1, 0, h, f, p, wv, wd);
    run_txn(6'd4, 0, 0, 0, 0, h, f, p, wv, wd);
    run_txn(6'd7, 0, 1, 0, 0, h, f, p, wv, wd);
    chk("lit_evict_wbvpn", wv, 0);
    chk("lit_evict_ppn", p, 1);
    chk("lit_model_e0", m_vpn[0], 7);
    chk("lit_model_rr", m_rr, 1);

    // Write hit on vpn 1, then evict it: dirty and ref must be written back.
    run_txn(6'd1, 1, 0, 0, 0, h, f, p, wv, wd);
    chk("lit_wr_hit", h, 1);
    run_txn(6'd9, 0, 2, 1, 0, h, f, p, wv, wd);
    chk("lit_wb1_vpn", wv, 1);
    chk("lit_wb1_dirty", wd, 1);

    // Flush during a walk: response still delivered, then everything invalid.
    run_txn(6'd10, 0, 0, 2, 1, h, f, p, wv, wd);
    chk("lit_flushwalk_fault", f, 0);
    run_txn(6'd0, 0, 0, 0, 0, h, f, p, wv, wd);
    chk("lit_after_flush_miss", h, 0);

    flush_idle();

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) flush_idle();
      else run_txn(6'($urandom_range(0, 11)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 9) == 0), h, f, p, wv, wd);
    end
`ifdef TLB_STATS_EN
    chk("stats_hit", hit_count, 16'(m_hitc));
    chk("stats_miss", miss_count, 16'(m_missc));
`endif

    flush_idle();
    reset_mid_walk(6'd5);
    run_txn(6'd0, 0, 0, 0, 0, h, f, p, wv, wd);
    chk("lit_post_reset_miss", h, 0);
    chk("lit_post_reset_ppn", p, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
